// File: rtl/chan_frame_decoder.sv
// chan_frame_decoder: byte-stream command decoder staging channel values in shadow registers with atomic commit.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx_data    received byte, qualified by rx_valid
//   rx_valid   one-cycle byte strobe
//   ch_data_o  committed channel values, channel i at [i*DATA_W +: DATA_W]
//   dirty_o    per-channel uncommitted shadow write flag
//   commit_o   one-cycle pulse when a commit is applied
//   run_o      run enable level
//   err_o      one-cycle pulse on a protocol error
//   timeout_o  one-cycle pulse when a frame is aborted by timeout
module chan_frame_decoder #(
    parameter int NUM_CH = 6,
    parameter int DATA_W = 11,
    parameter int TIMEOUT_CYC = 50000,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [NUM_CH*DATA_W-1:0] ch_data_o,
    output logic [NUM_CH-1:0]        dirty_o,
    output logic                     commit_o,
    output logic                     run_o,
    output logic                     err_o,
    output logic                     timeout_o
);
    localparam int HW = DATA_W - 6;
    localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
    typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI} state_t;
    state_t              r_state, w_state_nx;
    logic [IW-1:0]       r_ch;
    logic [5:0]          r_lo;
    logic [CW-1:0]       r_cnt;
    logic [DATA_W-1:0]   r_shadow [NUM_CH];
    logic [DATA_W-1:0]   r_out [NUM_CH];
    logic [NUM_CH-1:0]   r_dirty;
    logic                r_commit, r_run, r_err, r_to;
    logic [5:0]          w_idx;
    logic                w_sel_ok, w_ch_ld, w_lo_ld, w_wr, w_err, w_to;
    logic                w_commit, w_run_set, w_run_clr, w_disc;
    assign w_idx    = rx_data[5:0];
    assign w_sel_ok = (w_idx != 6'd0) && (w_idx <= 6'(NUM_CH));
    always_comb begin
        w_state_nx = r_state;
        w_ch_ld    = 1'b0;
        w_lo_ld    = 1'b0;
        w_wr       = 1'b0;
        w_err      = 1'b0;
        w_to       = 1'b0;
        w_commit   = 1'b0;
        w_run_set  = 1'b0;
        w_run_clr  = 1'b0;
        w_disc     = 1'b0;
        if (rx_valid) begin
            case (rx_data[7:6])
                2'b00: begin
                    w_ch_ld    = w_sel_ok;
                    w_err      = !w_sel_ok;
                    w_state_nx = w_sel_ok ? WAIT_LO : IDLE;
                end
                2'b01: begin
                    w_lo_ld    = r_state != IDLE;
                    w_err      = r_state == IDLE;
                    w_state_nx = r_state == IDLE ? IDLE : WAIT_HI;
                end
                2'b10: begin
                    w_wr       = r_state == WAIT_HI;
                    w_err      = r_state != WAIT_HI;
                    w_state_nx = r_state == WAIT_HI ? WAIT_LO : r_state;
                end
                default: begin
                    w_commit  = w_idx == 6'd0;
                    w_run_set = w_idx == 6'd1;
                    w_run_clr = w_idx == 6'd2;
                    w_disc    = w_idx == 6'd3;
                    w_err     = w_idx > 6'd3;
                end
            endcase
        end else if (TIMEOUT_CYC > 0 && r_state != IDLE && r_cnt == TO_LAST) begin
            // a byte in the expiring cycle takes the branch above, so it always wins
            w_to       = 1'b1;
            w_state_nx = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_dirty  <= '0;
            r_commit <= 1'b0;
            r_run    <= 1'b0;
            r_err    <= 1'b0;
            r_to     <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_shadow[k] <= RESET_VAL;
                r_out[k]    <= RESET_VAL;
            end
        end else begin
            r_commit <= w_commit;
            r_err    <= w_err;
            r_to     <= w_to;
            r_cnt    <= (rx_valid || r_state == IDLE || w_to || TIMEOUT_CYC == 0) ? '0 : r_cnt + 1'b1;
            if (w_ch_ld) r_ch <= IW'(w_idx - 6'd1);
            if (w_lo_ld) r_lo <= w_idx;
            else if (w_to) r_lo <= '0;
            if (w_run_set) r_run <= 1'b1;
            else if (w_run_clr) r_run <= 1'b0;
            if (w_wr) begin
                r_shadow[r_ch] <= {rx_data[HW-1:0], r_lo};
                r_dirty[r_ch]  <= 1'b1;
            end
            if (w_commit) begin
                for (int k = 0; k < NUM_CH; k++)
                    if (r_dirty[k]) r_out[k] <= r_shadow[k];
                r_dirty <= '0;
            end
            if (w_disc) begin
                for (int k = 0; k < NUM_CH; k++) r_shadow[k] <= r_out[k];
                r_dirty <= '0;
            end
        end
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_out
        assign ch_data_o[i*DATA_W +: DATA_W] = r_out[i];
    end
    assign dirty_o   = r_dirty;
    assign commit_o  = r_commit;
    assign run_o     = r_run;
    assign err_o     = r_err;
    assign timeout_o = r_to;
endmodule

// File: tb/tb_chan_frame_decoder.sv
// tb_chan_frame_decoder: directed self-checking bench for chan_frame_decoder (NUM_CH=6, DATA_W=11, TIMEOUT_CYC=10).
module tb_chan_frame_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [65:0] ch_data_o;
    logic [5:0]  dirty_o;
    logic        commit_o, run_o, err_o, timeout_o;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [65:0] exp_ch;
    chan_frame_decoder #(
        .NUM_CH(6), .DATA_W(11), .TIMEOUT_CYC(10), .RESET_VAL(11'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .ch_data_o(ch_data_o), .dirty_o(dirty_o), .commit_o(commit_o),
        .run_o(run_o), .err_o(err_o), .timeout_o(timeout_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask
    initial begin
        do_reset();
        chk("rst_ch", ch_data_o, 66'd0);
        chk("rst_dirty", dirty_o, 6'd0);
        chk("rst_pulses", {commit_o, run_o, err_o, timeout_o}, 4'b0000);
        send(8'h02);
        send(8'h65);
        send(8'h8A);
        chk("wr_dirty", dirty_o, 6'b000010);
        chk("wr_ch_before_commit", ch_data_o, 66'd0);
        send(8'hC0);
        exp_ch = '0;
        exp_ch[11 +: 11] = 11'h2A5;
        chk("commit_ch", ch_data_o, exp_ch);
        chk("commit_pulse", commit_o, 1'b1);
        chk("commit_dirty", dirty_o, 6'd0);
        idle(1);
        chk("commit_once", commit_o, 1'b0);
        do_reset();
        send(8'h02);
        send(8'h65);
        send(8'h8A);
        send(8'h06);
        send(8'h41);
        send(8'h80);
        chk("two_dirty", dirty_o, 6'b100010);
        send(8'hC3);
        chk("disc_dirty", dirty_o, 6'd0);
        chk("disc_no_err", err_o, 1'b0);
        send(8'hC0);
        chk("disc_commit_pulse", commit_o, 1'b1);
        chk("disc_ch", ch_data_o, 66'd0);
        do_reset();
        send(8'h07);
        chk("err_sel7", err_o, 1'b1);
        send(8'h00);
        chk("err_sel0", err_o, 1'b1);
        send(8'h80);
        chk("err_hi_idle", err_o, 1'b1);
        idle(1);
        chk("err_pulse_end", err_o, 1'b0);
        do_reset();
        send(8'h81);
        chk("err_hi_after_rst", err_o, 1'b1);
        send(8'h02);
        send(8'h65);
        send(8'hC5);
        chk("err_bad_ctl", err_o, 1'b1);
        send(8'h8A);
        chk("bad_ctl_keep_state_err", err_o, 1'b0);
        chk("bad_ctl_keep_state_dirty", dirty_o, 6'b000010);
        do_reset();
        send(8'h03);
        send(8'h65);
        idle(9);
        chk("to_not_yet", timeout_o, 1'b0);
        idle(1);
        chk("to_pulse", timeout_o, 1'b1);
        idle(1);
        chk("to_pulse_end", timeout_o, 1'b0);
        send(8'h8A);
        chk("to_hi_err", err_o, 1'b1);
        chk("to_dirty", dirty_o, 6'd0);
        do_reset();
        send(8'h01);
        send(8'h7F);
        send(8'h9F);
        send(8'hC0);
        exp_ch = '0;
        exp_ch[0 +: 11] = 11'h7FF;
        chk("b2b_ch0", ch_data_o, exp_ch);
        send(8'hC1);
        chk("run_on", run_o, 1'b1);
        send(8'hC2);
        chk("run_off", run_o, 1'b0);
        send(8'hC1);
        send(8'h01);
        send(8'h65);
        rst_n = 1'b0;
        #1;
        chk("midrst_ch", ch_data_o, 66'd0);
        chk("midrst_run", run_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h8A);
        chk("midrst_hi_err", err_o, 1'b1);
        chk("midrst_dirty", dirty_o, 6'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
